// File: rtl/door_sequencer.sv
// Up/down door motor supervisor: turns local/remote request pulses into timed
// motor runs with dead time, obstruction reversal, travel timeout and sensor-fault lockout.
//   state   | meaning
//   S_IDLE  | motors off, waiting for a request edge
//   S_DEAD  | motors off for DEAD_CYC cycles before energising r_target direction
//   S_UP    | raising door until up limit, timeout or stop request
//   S_DOWN  | lowering door until down limit, obstruction, timeout or stop request
//   S_FAULT | locked out until reset or local button edge
module door_sequencer #(
  parameter int DEAD_CYC    = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int CW          = 16
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_req_local,
  input  logic i_req_remote,
  input  logic i_up_limit,
  input  logic i_dn_limit,
  input  logic i_obstruct,
  output logic o_motor_up,
  output logic o_motor_dn,
  output logic o_busy,
  output logic o_fault,
  output logic o_grant_src
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DEAD  = 3'd1,
    S_UP    = 3'd2,
    S_DOWN  = 3'd3,
    S_FAULT = 3'd4
  } state_t;

  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYC - 1);
  localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT_CYC - 1);
  localparam logic          TGT_UP    = 1'b0;
  localparam logic          TGT_DN    = 1'b1;

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_target;
  logic          r_motor_up;
  logic          r_motor_dn;
  logic          r_grant_src;
  logic          r_req_local_q;
  logic          r_req_remote_q;

  state_t        w_state_nxt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic          w_target_nxt;
  logic          w_grant_nxt;
  logic          w_edge_local;
  logic          w_edge_remote;
  logic          w_edge_any;
  logic          w_edge_src;
  logic          w_timeout;

  assign w_edge_local  = i_req_local & ~r_req_local_q;
  assign w_edge_remote = i_req_remote & ~r_req_remote_q;
  assign w_edge_any    = w_edge_local | w_edge_remote;
  // Local wins a tie, so the source is remote only when local did not fire.
  assign w_edge_src    = ~w_edge_local;
  assign w_cnt_inc     = r_cnt + CW'(1);
  assign w_timeout     = (r_cnt == TMO_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_target_nxt = r_target;
    w_grant_nxt  = r_grant_src;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (i_up_limit && i_dn_limit) begin
          w_state_nxt = S_FAULT;
        end else if (w_edge_any && !(i_up_limit && i_obstruct)) begin
          w_state_nxt  = S_DEAD;
          w_target_nxt = i_up_limit ? TGT_DN : TGT_UP;
          w_grant_nxt  = w_edge_src;
        end
      end
      S_DEAD: begin
        if (r_cnt == DEAD_LAST) begin
          w_state_nxt = (r_target == TGT_DN) ? S_DOWN : S_UP;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = w_cnt_inc;
        end
      end
      S_UP: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_up_limit) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
          w_cnt_nxt   = '0;
        end else if (w_edge_any) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_grant_nxt = w_edge_src;
        end
      end
      S_DOWN: begin
        w_cnt_nxt = w_cnt_inc;
        if (i_dn_limit) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end else if (i_obstruct) begin
          w_state_nxt  = S_DEAD;
          w_target_nxt = TGT_UP;
          w_cnt_nxt    = '0;
        end else if (w_timeout) begin
          w_state_nxt = S_FAULT;
          w_cnt_nxt   = '0;
        end else if (w_edge_any) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_grant_nxt = w_edge_src;
        end
      end
      S_FAULT: begin
        w_cnt_nxt = '0;
        if (w_edge_local) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Motor drives follow the next state so they switch on the same edge as the state.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_target       <= TGT_UP;
      r_motor_up     <= 1'b0;
      r_motor_dn     <= 1'b0;
      r_grant_src    <= 1'b0;
      r_req_local_q  <= 1'b1;
      r_req_remote_q <= 1'b1;
    end else begin
      r_state        <= w_state_nxt;
      r_cnt          <= w_cnt_nxt;
      r_target       <= w_target_nxt;
      r_motor_up     <= (w_state_nxt == S_UP);
      r_motor_dn     <= (w_state_nxt == S_DOWN);
      r_grant_src    <= w_grant_nxt;
      r_req_local_q  <= i_req_local;
      r_req_remote_q <= i_req_remote;
    end
  end

  assign o_motor_up  = r_motor_up;
  assign o_motor_dn  = r_motor_dn;
  assign o_busy      = (r_state == S_DEAD) || (r_state == S_UP) || (r_state == S_DOWN);
  assign o_fault     = (r_state == S_FAULT);
  assign o_grant_src = r_grant_src;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed scenarios plus random stimulus for door_sequencer, checked every cycle
// against a countdown-based behavioural model of the door.
module tb_door_sequencer;

  localparam int DEAD = 4;
  localparam int TMO  = 20;

  logic clk = 1'b0;
  logic rst, rl, rr, ul, dl, ob;
  logic o_motor_up, o_motor_dn, o_busy, o_fault, o_grant_src;

  int total = 0;
  int bad   = 0;

  // Model: mode 0 idle, 1 waiting out dead time, 2 running, 3 faulted.
  int   m_mode;
  int   m_dir;
  int   m_left;
  logic m_grant;
  logic m_prev_l, m_prev_r;

  door_sequencer #(.DEAD_CYC(DEAD), .TIMEOUT_CYC(TMO), .CW(16)) dut (
    .i_clk(clk), .i_rst(rst), .i_req_local(rl), .i_req_remote(rr),
    .i_up_limit(ul), .i_dn_limit(dl), .i_obstruct(ob),
    .o_motor_up(o_motor_up), .o_motor_dn(o_motor_dn), .o_busy(o_busy),
    .o_fault(o_fault), .o_grant_src(o_grant_src)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic s_rst, input logic s_l, input logic s_r,
                            input logic s_ul, input logic s_dl, input logic s_ob);
    logic el, er, any_req, src;
    bit   at_end;
    if (s_rst) begin
      m_mode = 0; m_dir = 1; m_left = 0; m_grant = 1'b0;
      m_prev_l = 1'b1; m_prev_r = 1'b1;
      return;
    end
    el = s_l & ~m_prev_l;
    er = s_r & ~m_prev_r;
    m_prev_l = s_l;
    m_prev_r = s_r;
    any_req = el | er;
    src = el ? 1'b0 : 1'b1;
    case (m_mode)
      0: begin
        if (s_ul && s_dl) m_mode = 3;
        else if (any_req) begin
          m_dir = s_ul ? -1 : 1;
          if (!(m_dir < 0 && s_ob)) begin
            m_mode = 1; m_left = DEAD; m_grant = src;
          end
        end
      end
      1: begin
        m_left = m_left - 1;
        if (m_left == 0) begin m_mode = 2; m_left = TMO; end
      end
      2: begin
        at_end = (m_dir > 0) ? s_ul : s_dl;
        if (at_end) m_mode = 0;
        else if (m_dir < 0 && s_ob) begin m_mode = 1; m_dir = 1; m_left = DEAD; end
        else if (m_left == 1) m_mode = 3;
        else if (any_req) begin m_mode = 0; m_grant = src; end
        else m_left = m_left - 1;
      end
      default: if (el) m_mode = 0;
    endcase
  endtask

  task automatic tick();
    logic s_rst, s_l, s_r, s_ul, s_dl, s_ob;
    s_rst = rst; s_l = rl; s_r = rr; s_ul = ul; s_dl = dl; s_ob = ob;
    @(posedge clk);
    model_step(s_rst, s_l, s_r, s_ul, s_dl, s_ob);
    #1;
    check("motor_up", int'(o_motor_up), int'(m_mode == 2 && m_dir > 0));
    check("motor_dn", int'(o_motor_dn), int'(m_mode == 2 && m_dir < 0));
    check("busy",     int'(o_busy),     int'(m_mode == 1 || m_mode == 2));
    check("fault",    int'(o_fault),    int'(m_mode == 3));
    check("grant",    int'(o_grant_src), int'(m_grant));
    check("excl",     int'(o_motor_up & o_motor_dn), 0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int n_up;
    m_mode = 0; m_dir = 1; m_left = 0; m_grant = 1'b0;
    m_prev_l = 1'b1; m_prev_r = 1'b1;
    rst = 1'b1; rl = 1'b1; rr = 1'b0; ul = 1'b0; dl = 1'b1; ob = 1'b0;

    // Reset with local button held through it
    tick();
    check("rst_motor_up", int'(o_motor_up), 0);
    check("rst_busy", int'(o_busy), 0);
    check("rst_fault", int'(o_fault), 0);
    check("rst_grant", int'(o_grant_src), 0);
    rst = 1'b0;
    ticks(3);
    check("held_no_motion", int'(o_busy), 0);
    rl = 1'b0; tick();

    // Open from closed
    rl = 1'b1; tick();
    check("open_busy", int'(o_busy), 1);
    rl = 1'b0; ticks(3);
    check("open_dead", int'(o_motor_up), 0);
    tick();
    check("open_motor_up", int'(o_motor_up), 1);
    dl = 1'b0; ticks(10);
    ul = 1'b1; tick();
    check("open_stop", int'(o_motor_up), 0);
    check("open_idle", int'(o_busy), 0);
    check("open_grant", int'(o_grant_src), 0);

    // Simultaneous requests: local wins, then remote stop
    rl = 1'b1; rr = 1'b1; tick();
    check("arb_grant", int'(o_grant_src), 0);
    rl = 1'b0; rr = 1'b0; ticks(3);
    tick();
    check("arb_motor_dn", int'(o_motor_dn), 1);
    ul = 1'b0; ticks(2);
    rr = 1'b1; tick();
    check("arb_stop", int'(o_motor_dn), 0);
    check("arb_stop_idle", int'(o_busy), 0);
    check("arb_grant_remote", int'(o_grant_src), 1);
    rr = 1'b0; tick();

    // Obstruction reversal
    ul = 1'b1; rl = 1'b1; tick();
    rl = 1'b0; ticks(4);
    check("rev_down", int'(o_motor_dn), 1);
    ul = 1'b0; ticks(2);
    ob = 1'b1; tick();
    check("rev_dn_off", int'(o_motor_dn), 0);
    ob = 1'b0; ticks(3);
    check("rev_dead", int'(o_motor_up), 0);
    tick();
    check("rev_up", int'(o_motor_up), 1);
    ul = 1'b1; tick();

    // Travel timeout
    ul = 1'b0; dl = 1'b1; rl = 1'b1; tick();
    rl = 1'b0; ticks(4);
    dl = 1'b0;
    n_up = o_motor_up ? 1 : 0;
    for (int g = 0; g < 60 && o_motor_up; g++) begin
      tick();
      if (o_motor_up) n_up++;
    end
    check("tmo_cycles", n_up, TMO);
    check("tmo_fault", int'(o_fault), 1);
    check("tmo_busy", int'(o_busy), 0);
    rr = 1'b1; tick();
    check("tmo_remote_ignored", int'(o_fault), 1);
    rr = 1'b0; rl = 1'b1; tick();
    check("tmo_local_clear", int'(o_fault), 0);
    rl = 1'b0; tick();

    // Sensor fault, then refusal with obstruct while open
    ul = 1'b1; dl = 1'b1; tick();
    check("sensor_fault", int'(o_fault), 1);
    rl = 1'b1; dl = 1'b0; tick();
    rl = 1'b0; tick();
    ob = 1'b1; rr = 1'b1; tick();
    check("refuse_busy", int'(o_busy), 0);
    check("refuse_motor", int'(o_motor_dn), 0);
    check("refuse_grant", int'(o_grant_src), 0);
    ticks(2);
    check("refuse_stays", int'(o_busy), 0);
    rr = 1'b0; ob = 1'b0; ul = 1'b0; tick();

    // Reset mid-travel with local held
    dl = 1'b1; rl = 1'b1; tick();
    rl = 1'b0; ticks(4);
    check("mid_up", int'(o_motor_up), 1);
    dl = 1'b0; rst = 1'b1; rl = 1'b1; tick();
    check("mid_rst_motor", int'(o_motor_up), 0);
    check("mid_rst_busy", int'(o_busy), 0);
    rst = 1'b0; ticks(5);
    check("mid_held", int'(o_busy), 0);
    rl = 1'b0; tick();
    rl = 1'b1; tick();
    check("mid_repress", int'(o_busy), 1);
    rl = 1'b0; ticks(8);

    // Random stimulus
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 7) == 0) rl = ~rl;
      if ($urandom_range(0, 7) == 0) rr = ~rr;
      if ($urandom_range(0, 29) == 0) ul = ~ul;
      if ($urandom_range(0, 29) == 0) dl = ~dl;
      if ($urandom_range(0, 19) == 0) ob = ~ob;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/door_sequencer.md
# door_sequencer

Supervisory controller that sequences a single up/down door motor and shares it between two requesters: a local wall button and a remote receiver. It sits above the motor drive outputs, converts request pulses into timed motor runs, and adds direction-change dead time, obstruction reversal on closing, travel timeout and sensor-fault detection.

## Interface
- DEAD_CYC, default 4: motor-off cycles inserted before any motor is energised (≥1).
- TIMEOUT_CYC, default 1000: maximum cycles in a travel state before fault (≥2).
- CW, default 16: width of the shared cycle counter; must satisfy 2^CW > max(DEAD_CYC, TIMEOUT_CYC).
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_local  in  1  wall-button level; acted on at its rising edge.
- req_remote  in  1  remote-receiver level; acted on at its rising edge.
- up_limit  in  1  door fully open.
- dn_limit  in  1  door fully closed.
- obstruct  in  1  obstruction beam broken.
- motor_up  out  1  registered drive, raise door.
- motor_dn  out  1  registered drive, lower door.
- busy  out  1  high in DEAD, UP or DOWN.
- fault  out  1  high in FAULT.
- grant_src  out  1  source of the last accepted request: 0 local, 1 remote.

## Operation
- Edge detect: req_x_q registers each request. edge_x = req_x & ~req_x_q. Both req_x_q reset to 1, so a request held through reset must be released and re-pressed.
- Arbitration: a request is accepted only in IDLE, UP or DOWN. On simultaneous edges, local wins and the remote edge is dropped. grant_src updates on acceptance only.
- IDLE: motors off.
  - If up_limit & dn_limit → FAULT.
  - Otherwise, on an accepted edge, target = DOWN if up_limit, else UP.
  - Target DOWN with obstruct=1 → request refused; stay in IDLE, grant_src unchanged.
  - Otherwise → DEAD, cnt=0.
- DEAD: motors off; cnt increments. Request edges are ignored. When cnt==DEAD_CYC-1 → target state (UP/DOWN), cnt=0, matching motor output set.
- UP: motor_up=1; cnt increments. Priority:
  1. up_limit → IDLE.
  2. cnt==TIMEOUT_CYC-1 → FAULT.
  3. Accepted request edge → IDLE (stop).
  - obstruct is ignored.
- DOWN: motor_dn=1; cnt increments. Priority:
  1. dn_limit → IDLE.
  2. obstruct → DEAD with target UP, cnt=0 (reversal).
  3. Timeout → FAULT.
  4. Accepted request edge → IDLE.
- FAULT: motors off; fault=1. A req_local edge → IDLE, fault cleared. Remote edges are ignored. Only rst or the local button clears the fault.
- Invariant: motor_up & motor_dn never both 1. Every direction reversal passes through DEAD.
- State encoding: IDLE, DEAD, UP, DOWN, FAULT (3-bit). target is a registered 1-bit field.

## Timing
- Reset (rst sampled high at an edge): state=IDLE, cnt=0, target=UP, motor_up=0, motor_dn=0, busy=0, fault=0, grant_src=0, req_local_q=req_remote_q=1. Reset mid-travel drops the motors at that same edge.
- Request-to-motor latency: request edge sampled at clock edge k → busy=1 after edge k → motor output high after edge k+DEAD_CYC.
- Stop latency: a limit, obstruct, timeout or stop request sampled at edge m → motor output 0 after edge m.
- Timeout: the motor stays on for exactly TIMEOUT_CYC cycles, then fault=1 from the following edge.
- A limit asserted in the same cycle as the timeout wins: → IDLE, no fault.
- Reversal: obstruct sampled at edge m → motor_dn=0 after m → motor_up=1 after edge m+DEAD_CYC.
- busy and fault are decoded directly from the registered state; no extra latency.

## Test plan
- Open from closed: dn_limit=1, local edge at k → motor_up=1 after k+4. Assert up_limit 10 cycles later → motor_up=0 next edge, busy=0, grant_src=0.
- Arbitration: both requests rise at the same edge with up_limit=1 → grant_src=0, motor_dn=1 after 4 cycles. A remote rising edge 3 cycles later (in DOWN) → stop to IDLE, grant_src=1.
- Obstruction reversal: in DOWN, pulse obstruct for 1 cycle → motor_dn=0 next edge, motor_up=1 4 edges after that, motor_dn and motor_up never high together.
- Timeout: TIMEOUT_CYC=20, in UP with no limits → motor_up high 20 cycles, then fault=1, busy=0. A remote edge leaves fault=1; a local edge → fault=0, IDLE.
- Sensor fault and refusal: up_limit=dn_limit=1 in IDLE → FAULT next edge. Separately, up_limit=1 with obstruct=1 plus a request → stays IDLE, motors 0.
- Reset mid-operation: rst for 1 cycle while motor_up=1 → all outputs at reset values next edge. req_local held high through rst produces no motion until released and re-pressed.
